// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: stopwatch/calculator mode keys plus a shift-add-3 BCD formatter for the digit display.
module display_mode_ctrl #(
    parameter int NDIGITS = 4,
    parameter int VAL_W   = 32,
    parameter bit LZB     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             key,
    input  logic                   key_valid,
    input  logic [VAL_W-1:0]       sw_value,
    input  logic [VAL_W-1:0]       calc_answer,
    input  logic                   calc_neg,
    output logic                   mode,
    output logic [1:0]             sw_cmd,
    output logic [4*NDIGITS-1:0]   digits,
    output logic                   digits_ready,
    output logic                   overflow
);
    typedef enum logic [1:0] {LOAD, SHIFT, FORMAT} state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int CW = $clog2(VAL_W + 1);
    localparam logic [63:0] LIM_POS = pow10(NDIGITS);
    localparam logic [63:0] LIM_NEG = pow10(NDIGITS - 1);
    localparam logic [4*NDIGITS-1:0] BLANKS = {NDIGITS{4'd11}};

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [1:0]           sw_cmd_q, sw_cmd_d;
    logic [VAL_W-1:0]     frozen_q, frozen_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [VAL_W-1:0]     bin_q, bin_d;
    logic [4*NDIGITS-1:0] bcd_q, bcd_d;
    logic                 neg_q, neg_d;
    logic                 ovf_q, ovf_d;
    logic [4*NDIGITS-1:0] digits_q, digits_d;
    logic                 ready_q, ready_d;
    logic                 overflow_q, overflow_d;
    logic [VAL_W-1:0]     mag;
    logic                 sneg;
    logic                 seen;
    logic [4*NDIGITS-1:0] bcd_adj;
    logic [4*NDIGITS-1:0] fmt;

    always_comb begin
        mag  = mode_q ? calc_answer : frozen_q;
        sneg = mode_q & calc_neg;
        seen = 1'b0;
        for (int i = 0; i < NDIGITS; i++)
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        // Scan from the MS digit down so blanking stops at the first nonzero digit.
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            seen = seen | (bcd_q[4*i +: 4] != 4'd0) | (i == 0);
            fmt[4*i +: 4] = ovf_q ? 4'd10 :
                            (neg_q && i == NDIGITS - 1) ? 4'd10 :
                            (LZB && !seen) ? 4'd11 : bcd_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sw_cmd_d   = sw_cmd_q;
        frozen_d   = frozen_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        digits_d   = digits_q;
        ready_d    = ready_q;
        overflow_d = overflow_q;
        case (state_q)
            LOAD: begin
                bin_d   = mag;
                neg_d   = sneg;
                ovf_d   = 64'(mag) >= (sneg ? LIM_NEG : LIM_POS);
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(VAL_W - 1)) ? FORMAT : SHIFT;
            end
            default: begin
                digits_d   = fmt;
                overflow_d = ovf_q;
                ready_d    = 1'b1;
                state_d    = LOAD;
            end
        endcase
        if (key_valid && !mode_q) begin
            case (key)
                4'd10: begin sw_cmd_d = 2'd2; frozen_d = '0; end
                4'd11: begin sw_cmd_d = 2'd1; frozen_d = sw_value; end
                4'd12: sw_cmd_d = 2'd1;
                4'd13: sw_cmd_d = 2'd0;
                4'd14, 4'd15: mode_d = 1'b1;
                default: ;
            endcase
        end else if (key_valid && key == 4'd13) begin
            mode_d = 1'b0;
        end
        if (mode_d != mode_q) begin
            state_d    = LOAD;
            digits_d   = BLANKS;
            ready_d    = 1'b0;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            mode_q     <= 1'b0;
            sw_cmd_q   <= 2'd0;
            frozen_q   <= '0;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            digits_q   <= BLANKS;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sw_cmd_q   <= sw_cmd_d;
            frozen_q   <= frozen_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            digits_q   <= digits_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    assign mode         = mode_q;
    assign sw_cmd       = sw_cmd_q;
    assign digits       = digits_q;
    assign digits_ready = ready_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_display_mode_ctrl.sv
// tb_display_mode_ctrl: directed and random checks of two display_mode_ctrl instances (LZB 0 and 1) against a decimal reference model.
module tb_display_mode_ctrl;
    localparam int N = 4;
    localparam int W = 16;
    localparam int P = W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_valid = 1'b0;
    logic calc_neg = 1'b0;
    logic [3:0] key = 4'd0;
    logic [W-1:0] sw_value = '0;
    logic [W-1:0] calc_answer = '0;
    logic mode0, mode1, rdy0, rdy1, ov0, ov1;
    logic [1:0] cmd0, cmd1;
    logic [4*N-1:0] dig0, dig1;
    int total = 0;
    int bad = 0;

    bit m_mode;
    logic [1:0] m_cmd;
    logic [W-1:0] m_frozen, m_mag;
    bit m_neg, m_rdy, m_ov;
    int m_pos;
    logic [4*N-1:0] m_dig[2];

    always #5 clk = ~clk;

    display_mode_ctrl #(.NDIGITS(N), .VAL_W(W), .LZB(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .sw_value(sw_value),
        .calc_answer(calc_answer), .calc_neg(calc_neg), .mode(mode0), .sw_cmd(cmd0),
        .digits(dig0), .digits_ready(rdy0), .overflow(ov0));

    display_mode_ctrl #(.NDIGITS(N), .VAL_W(W), .LZB(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .sw_value(sw_value),
        .calc_answer(calc_answer), .calc_neg(calc_neg), .mode(mode1), .sw_cmd(cmd1),
        .digits(dig1), .digits_ready(rdy1), .overflow(ov1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned limit(input bit neg);
        int unsigned l = 1;
        for (int i = 0; i < (neg ? N - 1 : N); i++) l *= 10;
        return l;
    endfunction

    function automatic logic [4*N-1:0] expect_digits(input int unsigned mag, input bit neg, input bit lzb);
        logic [4*N-1:0] r;
        int unsigned t = mag;
        int nd = 1;
        if (mag >= limit(neg)) return {N{4'd10}};
        while (t >= 10) begin t /= 10; nd++; end
        t = mag;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = (lzb && i >= nd) ? 4'd11 : 4'(t % 10);
            t /= 10;
        end
        if (neg) r[4*N-1 -: 4] = 4'd10;
        return r;
    endfunction

    task automatic model_step();
        bit nm;
        if (!rst_n) begin
            m_mode = 0; m_cmd = 0; m_frozen = 0; m_pos = 0; m_rdy = 0; m_ov = 0;
            m_dig[0] = {N{4'd11}}; m_dig[1] = {N{4'd11}};
            return;
        end
        nm = m_mode;
        if (key_valid) nm = m_mode ? (key != 4'd13) : (key >= 4'd14);
        if (m_pos == 0) begin
            m_mag = m_mode ? calc_answer : m_frozen;
            m_neg = m_mode && calc_neg;
        end
        if (nm != m_mode) begin
            m_pos = 0; m_rdy = 0;
            m_dig[0] = {N{4'd11}}; m_dig[1] = {N{4'd11}};
        end else begin
            if (m_pos == P - 1) begin
                m_dig[0] = expect_digits(m_mag, m_neg, 1'b0);
                m_dig[1] = expect_digits(m_mag, m_neg, 1'b1);
                m_ov = m_mag >= limit(m_neg);
                m_rdy = 1;
            end
            m_pos = (m_pos + 1) % P;
        end
        if (key_valid && !m_mode) begin
            case (key)
                4'd10: begin m_cmd = 2; m_frozen = 0; end
                4'd11: begin m_cmd = 1; m_frozen = sw_value; end
                4'd12: m_cmd = 1;
                4'd13: m_cmd = 0;
                default: ;
            endcase
        end
        m_mode = nm;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
            chk("mode0", mode0, m_mode);   chk("mode1", mode1, m_mode);
            chk("cmd0", cmd0, m_cmd);      chk("cmd1", cmd1, m_cmd);
            chk("rdy0", rdy0, m_rdy);      chk("rdy1", rdy1, m_rdy);
            chk("ov0", ov0, m_ov);         chk("ov1", ov1, m_ov);
            chk("dig0", dig0, m_dig[0]);   chk("dig1", dig1, m_dig[1]);
        end
    endtask

    task automatic strobe(input logic [3:0] k);
        key = k;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return W'(999);
            1: return W'(1000);
            2: return W'(9999);
            3: return W'(10000);
            4: return W'($urandom_range(0, 65535));
            default: return W'($urandom_range(0, 200));
        endcase
    endfunction

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick(17);
        chk("rdy_before_18", rdy0, 0);
        tick(1);
        chk("rdy_at_18", rdy0, 1);
        chk("zero_digits", dig0, 16'h0000);
        chk("zero_lzb", dig1, 16'hBBB0);
        chk("cmd_idle", cmd0, 0);

        sw_value = W'(1234);
        strobe(4'd11);
        chk("cmd_run", cmd0, 1);
        tick(36);
        chk("sw_1234", dig0, 16'h1234);
        strobe(4'd10);
        chk("cmd_clear", cmd0, 2);
        tick(36);
        chk("sw_cleared", dig0, 16'h0000);

        sw_value = W'(5);
        strobe(4'd11);
        tick(36);
        chk("sw_5", dig0, 16'h0005);
        chk("sw_5_lzb", dig1, 16'hBBB5);

        calc_answer = W'(57);
        calc_neg = 1'b1;
        strobe(4'd14);
        chk("to_calc_mode", mode0, 1);
        chk("to_calc_blank", dig0, 16'hBBBB);
        chk("to_calc_rdy", rdy0, 0);
        tick(18);
        chk("calc_m57", dig0, 16'hA057);
        chk("calc_m57_lzb", dig1, 16'hAB57);
        chk("calc_m57_rdy", rdy0, 1);

        calc_answer = W'(10000);
        calc_neg = 1'b0;
        tick(36);
        chk("ovf_digits", dig0, 16'hAAAA);
        chk("ovf_flag", ov0, 1);
        calc_answer = W'(999);
        calc_neg = 1'b1;
        tick(36);
        chk("m999_digits", dig0, 16'hA999);
        chk("m999_flag", ov0, 0);

        for (int g = 0; g < P && m_pos != 8; g++) tick(1);
        strobe(4'd13);
        chk("abort_mode", mode0, 0);
        chk("abort_rdy", rdy0, 0);
        chk("abort_blank", dig0, 16'hBBBB);
        chk("abort_cmd", cmd0, 1);
        tick(18);
        chk("back_frozen", dig0, 16'h0005);
        chk("back_frozen_lzb", dig1, 16'hBBB5);

        for (int g = 0; g < P && m_pos != 9; g++) tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("rst_mode", mode0, 0);
        chk("rst_cmd", cmd0, 0);
        chk("rst_rdy", rdy0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_digits", dig0, 16'hBBBB);
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            key_valid = ($urandom_range(0, 23) == 0);
            key = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(10, 15));
            sw_value = pick();
            calc_answer = pick();
            calc_neg = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        key_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
